inst_receiver: RTL and testbench
================================

// Module: inst_receiver
// PURPOSE
//  AXI4 full slave that takes instruction words from the host into a circular instruction buffer.
//  Hands the buffered words one by one to the execution core over a valid/next interface.
//  Captures per-instruction results from the core into a result buffer, which the host reads back over AXI.
//  Sits between the host interconnect and the TPU control core.
// PARAMETERS
//  INSTRUCTION_DEPTH 16  entries in the instruction and result buffers (power of 2); IW = $clog2(depth)
//  DATA_WIDTH        64  AXI data width = instruction/result word width; STRB_WIDTH = DATA_WIDTH/8
//  ADDR_WIDTH        64  AXI address width
//  ID_WIDTH          4   AXI ID width
// PORTS
//  clk                 in   1   single clock; all logic on posedge
//  rst                 in   1   one clock; reset is asynchronous and active-low
//  S_AXI_AW{ADDR,ID,LEN,SIZE,BURST}  in  ADDR_WIDTH/ID_WIDTH/8/3/2  write address fields
//  S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1   write address handshake
//  S_AXI_WDATA in DATA_WIDTH, S_AXI_WSTRB in STRB_WIDTH, S_AXI_WLAST in 1   write data beat
//  S_AXI_WVALID in 1 / S_AXI_WREADY out 1     write data handshake
//  S_AXI_BID out ID_WIDTH, S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1   write response
//  S_AXI_AR{ADDR,ID,LEN,SIZE,BURST}  in  same widths as AW   read address fields
//  S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1   read address handshake
//  S_AXI_RID out ID_WIDTH, S_AXI_RDATA out DATA_WIDTH, S_AXI_RRESP out 2, S_AXI_RLAST out 1   read data
//  S_AXI_RVALID out 1 / S_AXI_RREADY in 1     read data handshake
//  instruction         out  DATA_WIDTH  instruction word at the head pointer; 0 when not valid
//  instruction_id      out  IW          buffer index of that instruction
//  instruction_valid   out  1           head entry holds an unconsumed instruction
//  instruction_next    in   1           consume: head advances when valid && next
//  data                in   DATA_WIDTH  result word from the core
//  data_id             in   IW          result buffer index to write
//  data_valid          in   1           write data into result[data_id] this cycle
// BEHAVIOUR
//  Reset (rst=0, async)
//   - All READY/VALID outputs 0; B/R fields 0.
//   - Both buffers and all pending bits cleared; head pointer 0.
//  Word index
//   - index = addr[log2(STRB_WIDTH) +: IW]; upper address bits are ignored.
//   - INCR and WRAP bursts: index+1 per beat, modulo DEPTH. FIXED: index constant.
//   - AxSIZE ignored: every beat is one full word.
//  Write FSM W_IDLE -> W_DATA -> W_RESP
//   - W_IDLE: AWREADY=1. On AW handshake, latch index, AWID and AWLEN, then go to W_DATA.
//   - W_DATA: AWREADY=0, WREADY=1. On each W handshake, write instr[index] honouring WSTRB per byte, set pending[index], advance index.
//   - Burst ends on beat AWLEN (count = AWLEN+1); WLAST is ignored. Then go to W_RESP.
//   - W_RESP: BVALID=1, BID=latched ID, BRESP=OKAY. Return to W_IDLE on BREADY.
//   - AWVALID held high during W_DATA/W_RESP is not accepted again.
//  Instruction port
//   - instruction_valid = pending[head].
//   - On valid && next: clear pending[head], head <= head+1 (wrap modulo DEPTH).
//   - One instruction per cycle is allowed while next is held high.
//   - In-order only; never skips a non-pending head.
//   - AXI write and consume on the same index in the same cycle: pending stays set (the new word wins).
//   - Writes to an entry that is still pending overwrite it silently; flow control is the host's responsibility.
//  Result port
//   - data_valid=1: result[data_id] <= data on the next edge.
//   - No handshake; always accepted.
//  Read FSM R_IDLE -> R_DATA
//   - R_IDLE: ARREADY=1. On AR handshake, latch index, ARID and ARLEN.
//   - R_DATA: RVALID=1, RDATA=result[index], RID=latched ID, RRESP=OKAY, RLAST on beat ARLEN.
//   - On RREADY: advance index (wrap). After the last beat, return to R_IDLE.
//   - Read and write channels run fully independently.
//   - data_valid to the index being presented updates RDATA on the following cycle.
// STRUCTURE
//  - Shared package: AXI burst type and response constants (OKAY=2'b00, FIXED/INCR/WRAP), FSM state enums.
//  - One natural sub-module: inst_receiver_axi_wr, the write FSM plus burst address generator.
//  - The read side and the buffers stay in the top level.
// TESTING
//  1 Single write, AWID=1, addr 0, LEN 0, data DEADBEEF_DEADBEEF, STRB FF
//    -> BVALID with BID=1, BRESP=0; instruction_valid=1, instruction_id=0.
//  2 Burst, AWID=2, addr 0x8, LEN 3, data A5A5A5A5_0000000i
//    -> 4 WREADY beats; entries 1..4 hold the words; one BVALID with BID=2.
//  3 instruction_next held high, data=~instruction, data_id=instruction_id
//    -> ids 0,1,2,3,4 in consecutive cycles; instruction_valid drops after id 4; result[k]=~instr[k].
//  4 Read, ARID=3, addr 0, ARLEN 4, RREADY=1
//    -> 5 beats with RDATA = ~DEADBEEF_DEADBEEF, ~A5A5A5A5_00000000..~A5A5A5A5_00000003; RLAST on beat 5; RID=3.
//  5 Write 17 beats from addr 0 -> index wraps to 0; WSTRB=0x0F updates only the low 4 bytes.
//  6 Assert rst mid-burst -> all VALID/READY outputs drop immediately; instruction_valid=0; FSMs back in idle.

Source files
------------

// File: rtl/inst_receiver_pkg.sv
// Shared AXI constants and FSM state types for the instruction receiver.
package inst_receiver_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   // FIXED bursts keep hammering one word; INCR and WRAP both step modulo the buffer depth.
   function automatic logic burst_steps(input logic [1:0] burst);
      return burst != BURST_FIXED;
   endfunction

endpackage

// File: rtl/inst_receiver_axi_wr.sv
// AXI write channel: AW/W/B FSM plus burst word-index generator; one beat per cycle, one cycle AW->W turnaround.
// Backpressure: AWREADY only in idle, WREADY only while the burst is open, waits on BREADY before the next burst.
module inst_receiver_axi_wr
   import inst_receiver_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 64,
   parameter int IW         = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [ID_WIDTH-1:0]   awid,
   input  logic [7:0]            awlen,
   input  logic [1:0]            awburst,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [ID_WIDTH-1:0]   bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   output logic                  wr_en,
   output logic [IW-1:0]         wr_index
);

   localparam int OFFS = $clog2(DATA_WIDTH / 8);

   w_state_t   state;
   logic [7:0] len;
   logic [7:0] cnt;
   logic [1:0] burst;

   assign wr_en = wvalid && wready;
   assign bresp = RESP_OKAY;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= W_IDLE;
         awready  <= 1'b0;
         wready   <= 1'b0;
         bvalid   <= 1'b0;
         bid      <= '0;
         wr_index <= '0;
         len      <= '0;
         cnt      <= '0;
         burst    <= BURST_FIXED;
      end else begin
         case (state)
            W_IDLE: begin
               awready <= 1'b1;
               if (awvalid && awready) begin
                  wr_index <= awaddr[OFFS +: IW];
                  bid      <= awid;
                  len      <= awlen;
                  cnt      <= '0;
                  burst    <= awburst;
                  awready  <= 1'b0;
                  wready   <= 1'b1;
                  state    <= W_DATA;
               end
            end
            W_DATA: begin
               // Beat count alone closes the burst; WLAST is not trusted.
               if (wvalid && wready) begin
                  if (burst_steps(burst))
                     wr_index <= wr_index + 1'b1;
                  cnt <= cnt + 1'b1;
                  if (cnt == len) begin
                     wready <= 1'b0;
                     bvalid <= 1'b1;
                     state  <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  awready <= 1'b1;
                  state   <= W_IDLE;
               end
            end
            default: state <= W_IDLE;
         endcase
      end
   end

   logic unused_addr;
   assign unused_addr = ^{awaddr[ADDR_WIDTH-1:OFFS+IW], awaddr[OFFS-1:0]};

endmodule

// File: rtl/inst_receiver.sv
// AXI4 slave feeding a circular instruction buffer to the core and returning core results to the host.
// Latency: written word visible next cycle; one instruction per cycle on next; reads stall only on RREADY.
module inst_receiver
   import inst_receiver_pkg::*;
#(
   parameter int  INSTRUCTION_DEPTH = 16,
   parameter int  DATA_WIDTH        = 64,
   parameter int  ADDR_WIDTH        = 64,
   parameter int  ID_WIDTH          = 4,
   localparam int IW                = $clog2(INSTRUCTION_DEPTH),
   localparam int STRB_WIDTH        = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [ID_WIDTH-1:0]   S_AXI_AWID,
   input  logic [7:0]            S_AXI_AWLEN,
   input  logic [2:0]            S_AXI_AWSIZE,
   input  logic [1:0]            S_AXI_AWBURST,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [STRB_WIDTH-1:0] S_AXI_WSTRB,
   input  logic                  S_AXI_WLAST,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   output logic [ID_WIDTH-1:0]   S_AXI_BID,
   output logic [1:0]            S_AXI_BRESP,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [ID_WIDTH-1:0]   S_AXI_ARID,
   input  logic [7:0]            S_AXI_ARLEN,
   input  logic [2:0]            S_AXI_ARSIZE,
   input  logic [1:0]            S_AXI_ARBURST,
   input  logic                  S_AXI_ARVALID,
   output logic                  S_AXI_ARREADY,
   output logic [ID_WIDTH-1:0]   S_AXI_RID,
   output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]            S_AXI_RRESP,
   output logic                  S_AXI_RLAST,
   output logic                  S_AXI_RVALID,
   input  logic                  S_AXI_RREADY,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic [IW-1:0]         instruction_id,
   output logic                  instruction_valid,
   input  logic                  instruction_next,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [IW-1:0]         data_id,
   input  logic                  data_valid
);

   localparam int OFFS = $clog2(STRB_WIDTH);

   logic                          wr_en;
   logic [IW-1:0]                 wr_index;
   logic [DATA_WIDTH-1:0]         instr_mem  [INSTRUCTION_DEPTH];
   logic [DATA_WIDTH-1:0]         result_mem [INSTRUCTION_DEPTH];
   logic [INSTRUCTION_DEPTH-1:0]  pending;
   logic [IW-1:0]                 head;
   logic                          consume;

   inst_receiver_axi_wr #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IW         (IW)
   ) u_axi_wr (
      .clk      (clk),
      .rst      (rst),
      .awaddr   (S_AXI_AWADDR),
      .awid     (S_AXI_AWID),
      .awlen    (S_AXI_AWLEN),
      .awburst  (S_AXI_AWBURST),
      .awvalid  (S_AXI_AWVALID),
      .awready  (S_AXI_AWREADY),
      .wvalid   (S_AXI_WVALID),
      .wready   (S_AXI_WREADY),
      .bid      (S_AXI_BID),
      .bresp    (S_AXI_BRESP),
      .bvalid   (S_AXI_BVALID),
      .bready   (S_AXI_BREADY),
      .wr_en    (wr_en),
      .wr_index (wr_index)
   );

   assign consume           = pending[head] && instruction_next;
   assign instruction_valid = pending[head];
   assign instruction_id    = head;
   assign instruction       = pending[head] ? instr_mem[head] : '0;

   // The write is ordered after the consume so a same-cycle write to the head leaves it pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < INSTRUCTION_DEPTH; i++)
            instr_mem[i] <= '0;
         pending <= '0;
         head    <= '0;
      end else begin
         if (consume) begin
            pending[head] <= 1'b0;
            head          <= head + 1'b1;
         end
         if (wr_en) begin
            pending[wr_index] <= 1'b1;
            for (int b = 0; b < STRB_WIDTH; b++)
               if (S_AXI_WSTRB[b])
                  instr_mem[wr_index][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < INSTRUCTION_DEPTH; i++)
            result_mem[i] <= '0;
      end else if (data_valid) begin
         result_mem[data_id] <= data;
      end
   end

   r_state_t      r_state;
   logic [IW-1:0] ridx;
   logic [7:0]    rlen;
   logic [7:0]    rcnt;
   logic [1:0]    rburst;

   // RDATA reads the result buffer live so a core update shows on the very next cycle.
   assign S_AXI_RDATA = S_AXI_RVALID ? result_mem[ridx] : '0;
   assign S_AXI_RLAST = S_AXI_RVALID && (rcnt == rlen);
   assign S_AXI_RRESP = RESP_OKAY;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= R_IDLE;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RID     <= '0;
         ridx          <= '0;
         rlen          <= '0;
         rcnt          <= '0;
         rburst        <= BURST_FIXED;
      end else begin
         case (r_state)
            R_IDLE: begin
               S_AXI_ARREADY <= 1'b1;
               if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                  ridx          <= S_AXI_ARADDR[OFFS +: IW];
                  S_AXI_RID     <= S_AXI_ARID;
                  rlen          <= S_AXI_ARLEN;
                  rcnt          <= '0;
                  rburst        <= S_AXI_ARBURST;
                  S_AXI_ARREADY <= 1'b0;
                  S_AXI_RVALID  <= 1'b1;
                  r_state       <= R_DATA;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  if (rcnt == rlen) begin
                     S_AXI_RVALID  <= 1'b0;
                     S_AXI_ARREADY <= 1'b1;
                     r_state       <= R_IDLE;
                  end else begin
                     rcnt <= rcnt + 1'b1;
                     if (burst_steps(rburst))
                        ridx <= ridx + 1'b1;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   logic unused_top;
   assign unused_top = ^{S_AXI_AWSIZE, S_AXI_WLAST, S_AXI_ARSIZE,
                         S_AXI_ARADDR[ADDR_WIDTH-1:OFFS+IW], S_AXI_ARADDR[OFFS-1:0]};

endmodule

// File: tb/tb_inst_receiver.sv
// Randomized bench for inst_receiver against a buffer-level reference model of the host/core view.
module tb_inst_receiver;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] S_AXI_AWADDR = '0;
   logic [3:0]  S_AXI_AWID = '0;
   logic [7:0]  S_AXI_AWLEN = '0;
   logic [2:0]  S_AXI_AWSIZE = 3'd3;
   logic [1:0]  S_AXI_AWBURST = 2'b01;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [63:0] S_AXI_WDATA = '0;
   logic [7:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WLAST = 1'b0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [3:0]  S_AXI_BID;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b0;
   logic [63:0] S_AXI_ARADDR = '0;
   logic [3:0]  S_AXI_ARID = '0;
   logic [7:0]  S_AXI_ARLEN = '0;
   logic [2:0]  S_AXI_ARSIZE = 3'd3;
   logic [1:0]  S_AXI_ARBURST = 2'b01;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [3:0]  S_AXI_RID;
   logic [63:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RLAST;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b0;
   logic [63:0] instruction;
   logic [3:0]  instruction_id;
   logic        instruction_valid;
   logic        instruction_next = 1'b0;
   logic [63:0] data = '0;
   logic [3:0]  data_id = '0;
   logic        data_valid = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [63:0] beat_data [256];
   logic [7:0]  beat_strb [256];

   logic [63:0] model_instr [16];
   logic        model_pend  [16];
   logic [63:0] model_res   [16];
   logic [3:0]  model_head;
   logic [3:0]  m_widx;
   logic [1:0]  m_wburst;

   inst_receiver dut (
      .clk(clk), .rst(rst),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWLEN(S_AXI_AWLEN),
      .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
      .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARID(S_AXI_ARID),
      .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RID(S_AXI_RID),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .instruction(instruction), .instruction_id(instruction_id),
      .instruction_valid(instruction_valid), .instruction_next(instruction_next),
      .data(data), .data_id(data_id), .data_valid(data_valid)
   );

   always #5 clk = ~clk;

   // Reference model: buffer contents, pending flags and head, updated at each edge from the bus activity.
   initial begin
      for (int i = 0; i < 16; i++) begin
         model_instr[i] = '0; model_pend[i] = 1'b0; model_res[i] = '0;
      end
      model_head = '0; m_widx = '0; m_wburst = '0;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            for (int i = 0; i < 16; i++) begin
               model_instr[i] = '0; model_pend[i] = 1'b0; model_res[i] = '0;
            end
            model_head = '0;
         end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
               m_widx   = S_AXI_AWADDR[3 +: 4];
               m_wburst = S_AXI_AWBURST;
            end
            if (instruction_next && model_pend[model_head]) begin
               model_pend[model_head] = 1'b0;
               model_head = model_head + 4'd1;
            end
            if (data_valid) model_res[data_id] = data;
            if (S_AXI_WVALID && S_AXI_WREADY) begin
               for (int b = 0; b < 8; b++)
                  if (S_AXI_WSTRB[b]) model_instr[m_widx][b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
               model_pend[m_widx] = 1'b1;
               if (m_wburst != 2'b00) m_widx = m_widx + 4'd1;
            end
         end
      end
   end

   function automatic logic [63:0] exp_instruction();
      return model_pend[model_head] ? model_instr[model_head] : 64'h0;
   endfunction

   task automatic axi_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit hold_aw, input bit rnd);
      int budget;
      int beats;
      S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWBURST = burst;
      S_AXI_AWSIZE = 3'($urandom_range(0, 7));
      S_AXI_AWVALID = 1'b1;
      budget = 0;
      @(negedge clk);
      while (!S_AXI_AWREADY && budget < 50) begin @(negedge clk); budget++; end
      checks++;
      if (S_AXI_AWREADY !== 1'b1) begin errors++; $display("FAIL aw_handshake: awready %b expected 1", S_AXI_AWREADY); end
      @(posedge clk); #1;
      if (!hold_aw) S_AXI_AWVALID = 1'b0;
      beats = 0; budget = 0;
      while (beats <= int'(len) && budget < 2000) begin
         S_AXI_WVALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         S_AXI_WDATA = beat_data[beats]; S_AXI_WSTRB = beat_strb[beats];
         S_AXI_WLAST = rnd ? 1'($urandom_range(0, 1)) : (beats == int'(len));
         @(negedge clk);
         if (hold_aw) begin
            checks++;
            if (S_AXI_AWREADY !== 1'b0) begin errors++; $display("FAIL aw_reaccept: awready %b expected 0", S_AXI_AWREADY); end
         end
         if (S_AXI_WVALID && S_AXI_WREADY) beats++;
         @(posedge clk); #1; budget++;
      end
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
      checks++;
      if (beats != int'(len) + 1) begin errors++; $display("FAIL w_beats: got %0d expected %0d", beats, int'(len) + 1); end
      S_AXI_BREADY = 1'b1;
      @(negedge clk);
      checks++;
      if (S_AXI_WREADY !== 1'b0) begin errors++; $display("FAIL w_extra_beat: wready %b expected 0", S_AXI_WREADY); end
      budget = 0;
      while (!S_AXI_BVALID && budget < 50) begin @(negedge clk); budget++; end
      checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BID !== id || S_AXI_BRESP !== 2'b00) begin
         errors++; $display("FAIL b_resp: bvalid %b bid %h bresp %h expected 1 %h 0", S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP, id);
      end
      @(posedge clk); #1;
      S_AXI_BREADY = 1'b0; S_AXI_AWVALID = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit rnd, input bit chk_first, input logic [63:0] first_exp);
      int budget;
      int beat;
      logic [3:0] idx;
      S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
      budget = 0;
      @(negedge clk);
      while (!S_AXI_ARREADY && budget < 50) begin @(negedge clk); budget++; end
      checks++;
      if (S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL ar_handshake: arready %b expected 1", S_AXI_ARREADY); end
      @(posedge clk); #1;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      idx = addr[3 +: 4]; beat = 0; budget = 0;
      while (beat <= int'(len) && budget < 1000) begin
         @(negedge clk); budget++;
         checks++;
         if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== model_res[idx] || S_AXI_RID !== id ||
             S_AXI_RRESP !== 2'b00 || S_AXI_RLAST !== (beat == int'(len))) begin
            errors++;
            $display("FAIL r_beat%0d: valid %b data %h id %h resp %h last %b expected 1 %h %h 0 %b",
                     beat, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST,
                     model_res[idx], id, (beat == int'(len)));
         end
         if (chk_first && beat == 0) begin
            checks++;
            if (S_AXI_RDATA !== first_exp) begin errors++; $display("FAIL r_first: got %h expected %h", S_AXI_RDATA, first_exp); end
         end
         if (S_AXI_RVALID && S_AXI_RREADY) begin
            beat++;
            if (burst != 2'b00) idx = idx + 4'd1;
         end
         @(posedge clk); #1;
         S_AXI_RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      S_AXI_RREADY = 1'b0;
      @(negedge clk);
      checks++;
      if (S_AXI_RVALID !== 1'b0) begin errors++; $display("FAIL r_end: rvalid %b expected 0", S_AXI_RVALID); end
      @(posedge clk); #1;
   endtask

   task automatic test_consume(input int cycles, input bit rnd, output int consumed);
      consumed = 0;
      for (int c = 0; c < cycles; c++) begin
         instruction_next = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         data_valid = model_pend[model_head];
         data = ~model_instr[model_head];
         data_id = model_head;
         @(negedge clk);
         checks++;
         if (instruction_valid !== model_pend[model_head] || instruction_id !== model_head ||
             instruction !== exp_instruction()) begin
            errors++;
            $display("FAIL consume: valid %b id %0d instr %h expected %b %0d %h",
                     instruction_valid, instruction_id, instruction, model_pend[model_head], model_head, exp_instruction());
         end
         if (instruction_next && model_pend[model_head]) consumed++;
         @(posedge clk); #1;
      end
      instruction_next = 1'b0; data_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST, instruction_valid} !== 7'b0 ||
          S_AXI_BID !== 4'h0 || S_AXI_BRESP !== 2'b00 || S_AXI_RID !== 4'h0 || S_AXI_RDATA !== 64'h0 ||
          S_AXI_RRESP !== 2'b00 || instruction !== 64'h0 || instruction_id !== 4'h0) begin
         errors++; $display("FAIL reset_outputs: awr %b wr %b bv %b arr %b rv %b iv %b expected all 0",
                            S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, instruction_valid);
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++;
      if (S_AXI_AWREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
         errors++; $display("FAIL idle_ready: awready %b arready %b expected 1 1", S_AXI_AWREADY, S_AXI_ARREADY);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_write();
      beat_data[0] = 64'hDEADBEEF_DEADBEEF; beat_strb[0] = 8'hFF;
      axi_write(4'd1, 64'h0, 8'd0, 2'b01, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (instruction_valid !== 1'b1 || instruction_id !== 4'd0 || instruction !== 64'hDEADBEEF_DEADBEEF) begin
         errors++; $display("FAIL single_write: valid %b id %0d instr %h expected 1 0 deadbeefdeadbeef",
                            instruction_valid, instruction_id, instruction);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_burst();
      for (int i = 0; i < 4; i++) begin beat_data[i] = 64'hA5A5A5A5_00000000 | 64'(i); beat_strb[i] = 8'hFF; end
      axi_write(4'd2, 64'h8, 8'd3, 2'b01, 1'b0, 1'b0);
   endtask

   task automatic test_drain();
      int n;
      test_consume(8, 1'b0, n);
      checks++;
      if (n != 5) begin errors++; $display("FAIL drain_count: got %0d expected 5", n); end
   endtask

   task automatic test_wrap_strb();
      int n;
      for (int i = 0; i < 17; i++) begin beat_data[i] = {$urandom, $urandom}; beat_strb[i] = 8'hFF; end
      beat_strb[16] = 8'h0F;
      axi_write(4'd4, 64'h0, 8'd16, 2'b01, 1'b0, 1'b1);
      test_consume(11, 1'b0, n);
      @(negedge clk);
      checks++;
      if (instruction_id !== 4'd0 || instruction !== {beat_data[0][63:32], beat_data[16][31:0]}) begin
         errors++; $display("FAIL wrap_strb: id %0d instr %h expected 0 %h", instruction_id, instruction,
                            {beat_data[0][63:32], beat_data[16][31:0]});
      end
      @(posedge clk); #1;
      test_consume(8, 1'b0, n);
      checks++;
      if (n != 5) begin errors++; $display("FAIL wrap_tail_count: got %0d expected 5", n); end
      axi_read(4'd9, 64'hFFFF_0000_0000_0048, 8'd15, 2'b10, 1'b1, 1'b0, 64'h0);
   endtask

   task automatic test_collision();
      int n;
      logic [3:0] h;
      h = model_head;
      beat_data[0] = {$urandom, $urandom}; beat_strb[0] = 8'hFF;
      axi_write(4'd6, {56'h0, h, 3'b000}, 8'd0, 2'b01, 1'b0, 1'b0);
      S_AXI_AWID = 4'd7; S_AXI_AWADDR = {56'h0, h, 3'b000}; S_AXI_AWLEN = 8'd0; S_AXI_AWVALID = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 50 && !S_AXI_AWREADY; k++) @(negedge clk);
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID = 1'b1; S_AXI_WDATA = {$urandom, $urandom}; S_AXI_WSTRB = 8'hFF; S_AXI_WLAST = 1'b1;
      instruction_next = 1'b1;
      @(posedge clk); #1;
      S_AXI_WVALID = 1'b0; instruction_next = 1'b0; S_AXI_BREADY = 1'b1;
      @(negedge clk);
      checks++;
      if (instruction_valid !== 1'b0 || instruction_id !== h + 4'd1) begin
         errors++; $display("FAIL collision_head: valid %b id %0d expected 0 %0d", instruction_valid, instruction_id, h + 4'd1);
      end
      @(posedge clk); #1; S_AXI_BREADY = 1'b0;
      for (int i = 0; i < 15; i++) begin beat_data[i] = {$urandom, $urandom}; beat_strb[i] = 8'($urandom); end
      axi_write(4'd8, {56'h0, h + 4'd1, 3'b000}, 8'd14, 2'b01, 1'b0, 1'b1);
      test_consume(20, 1'b0, n);
      checks++;
      if (n != 16) begin errors++; $display("FAIL collision_count: got %0d expected 16", n); end
   endtask

   task automatic test_random();
      int n;
      fork
         for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(0, 5);
            for (int i = 0; i <= len; i++) begin beat_data[i] = {$urandom, $urandom}; beat_strb[i] = 8'($urandom); end
            axi_write(4'($urandom), {$urandom, $urandom}, 8'(len), 2'($urandom_range(0, 2)), 1'b0, 1'b1);
         end
         test_consume(150, 1'b1, n);
         for (int t = 0; t < 4; t++)
            axi_read(4'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), 1'b1, 1'b0, 64'h0);
      join
      test_consume(20, 1'b0, n);
      axi_read(4'hC, 64'h0, 8'd15, 2'b01, 1'b0, 1'b0, 64'h0);
   endtask

   task automatic test_reset_mid_burst();
      int n;
      S_AXI_ARID = 4'd5; S_AXI_ARADDR = 64'h0; S_AXI_ARLEN = 8'd3; S_AXI_ARVALID = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 50 && !S_AXI_ARREADY; k++) @(negedge clk);
      @(posedge clk); #1; S_AXI_ARVALID = 1'b0;
      S_AXI_AWID = 4'd3; S_AXI_AWADDR = 64'h40; S_AXI_AWLEN = 8'd7; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 50 && !S_AXI_AWREADY; k++) @(negedge clk);
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b1; S_AXI_WDATA = {$urandom, $urandom}; S_AXI_WSTRB = 8'hFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST, instruction_valid} !== 7'b0 ||
          S_AXI_RDATA !== 64'h0 || instruction !== 64'h0) begin
         errors++; $display("FAIL mid_reset: awr %b wr %b bv %b arr %b rv %b iv %b expected all 0",
                            S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, instruction_valid);
      end
      S_AXI_WVALID = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++;
      if (S_AXI_AWREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1 || S_AXI_WREADY !== 1'b0 || S_AXI_RVALID !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: awr %b arr %b wr %b rv %b expected 1 1 0 0",
                            S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_RVALID);
      end
      @(posedge clk); #1;
      beat_data[0] = {$urandom, $urandom}; beat_strb[0] = 8'hFF;
      axi_write(4'd1, 64'h0, 8'd0, 2'b00, 1'b0, 1'b0);
      test_consume(3, 1'b0, n);
      checks++;
      if (n != 1) begin errors++; $display("FAIL post_reset_consume: got %0d expected 1", n); end
      axi_read(4'd2, 64'h0, 8'd2, 2'b00, 1'b0, 1'b1, ~beat_data[0]);
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst();
      test_drain();
      axi_read(4'd3, 64'h0, 8'd4, 2'b01, 1'b0, 1'b1, ~64'hDEADBEEF_DEADBEEF);
      test_wrap_strb();
      test_collision();
      test_random();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
